// File: rtl/unidade_controle_jogo_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : unidade_controle_jogo_pkg                              |
// | Description : State codes, state type and mode limits shared by the  |
// |               memory-game controller and its datapath.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package unidade_controle_jogo_pkg;

   // Display codes of the controller states
   localparam logic [3:0] C_ST_INICIAL        = 4'b0000;
   localparam logic [3:0] C_ST_PREPARACAO     = 4'b0001;
   localparam logic [3:0] C_ST_INICIA_RODADA  = 4'b0010;
   localparam logic [3:0] C_ST_ESPERA_JOGADA  = 4'b0011;
   localparam logic [3:0] C_ST_REGISTRA       = 4'b0100;
   localparam logic [3:0] C_ST_COMPARACAO     = 4'b0101;
   localparam logic [3:0] C_ST_PROXIMA_JOGADA = 4'b0110;
   localparam logic [3:0] C_ST_PROXIMA_RODADA = 4'b0111;
   localparam logic [3:0] C_ST_FIM_ACERTOU    = 4'b1010;
   localparam logic [3:0] C_ST_FIM_ERROU      = 4'b1110;
   localparam logic [3:0] C_ST_FIM_TIMEOUT    = 4'b1101;
   localparam logic [3:0] C_ST_INVALIDO       = 4'b1111;

   // Last round index for each game mode (mode 0: 16 rounds, mode 1: 4 rounds)
   localparam logic [3:0] C_LIMITE_MODO0 = 4'b1111;
   localparam logic [3:0] C_LIMITE_MODO1 = 4'b0011;

   typedef enum logic [3:0] {
      ST_INICIAL        = C_ST_INICIAL,
      ST_PREPARACAO     = C_ST_PREPARACAO,
      ST_INICIA_RODADA  = C_ST_INICIA_RODADA,
      ST_ESPERA_JOGADA  = C_ST_ESPERA_JOGADA,
      ST_REGISTRA       = C_ST_REGISTRA,
      ST_COMPARACAO     = C_ST_COMPARACAO,
      ST_PROXIMA_JOGADA = C_ST_PROXIMA_JOGADA,
      ST_PROXIMA_RODADA = C_ST_PROXIMA_RODADA,
      ST_FIM_ACERTOU    = C_ST_FIM_ACERTOU,
      ST_FIM_ERROU      = C_ST_FIM_ERROU,
      ST_FIM_TIMEOUT    = C_ST_FIM_TIMEOUT
   } estado_t;

   // Round limit selected by the latched game mode
   function automatic logic [3:0] limite_modo(input logic modo);
      return modo ? C_LIMITE_MODO1 : C_LIMITE_MODO0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/unidade_controle_jogo_if.sv
// +----------------------------------------------------------------------+
// | Module      : unidade_controle_jogo_if                               |
// | Description : Controller <-> datapath signal bundle. The master      |
// |               side is the controller, the slave side the datapath.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface unidade_controle_jogo_if;
   // User requests
   logic       iniciar;
   logic       modo;
   // Datapath status flags
   logic       jogada_feita;
   logic       igual;
   logic       fimRodada;
   logic       fimTotal;
   logic       fimT;
   // Datapath controls
   logic       zeraCL;
   logic       contaCL;
   logic       zeraC;
   logic       contaC;
   logic       zeraR;
   logic       registraR;
   logic       conta;
   logic       modo_jogo;
   // Game result and display
   logic       pronto;
   logic       acertou;
   logic       errou;
   logic       timeout;
   logic [3:0] db_estado;

   modport master (
      input  iniciar, modo, jogada_feita, igual, fimRodada, fimTotal, fimT,
      output zeraCL, contaCL, zeraC, contaC, zeraR, registraR, conta,
             modo_jogo, pronto, acertou, errou, timeout, db_estado
   );

   modport slave (
      output iniciar, modo, jogada_feita, igual, fimRodada, fimTotal, fimT,
      input  zeraCL, contaCL, zeraC, contaC, zeraR, registraR, conta,
             modo_jogo, pronto, acertou, errou, timeout, db_estado
   );
endinterface

`default_nettype wire

// File: rtl/unidade_controle_jogo.sv
// +----------------------------------------------------------------------+
// | Module      : unidade_controle_jogo                                  |
// | Description : Moore controller sequencing the memory-game datapath:  |
// |               round/play counters, play register, timeout counter   |
// |               and the hit / miss / timeout terminal states.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module unidade_controle_jogo
   import unidade_controle_jogo_pkg::*;
(
   input wire                        clock,
   input wire                        reset,
   unidade_controle_jogo_if.master   bus
);

   estado_t    r_estado;
   estado_t    w_proximo;
   logic       r_modo_jogo;

   logic       w_zeraCL;
   logic       w_contaCL;
   logic       w_zeraC;
   logic       w_contaC;
   logic       w_zeraR;
   logic       w_registraR;
   logic       w_conta;
   logic       w_pronto;
   logic       w_acertou;
   logic       w_errou;
   logic       w_timeout;
   logic [3:0] w_db_estado;

   // State register; reset drops the game back to idle without a clock edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_estado <= ST_INICIAL;
      else        r_estado <= w_proximo;
   end

   // Game mode is captured once per game, while the counters are being cleared
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                         r_modo_jogo <= 1'b0;
      else if (r_estado == ST_PREPARACAO) r_modo_jogo <= bus.modo;
   end

   // Next-state logic; iniciar is only honoured in idle and terminal states
   always_comb begin
      w_proximo = ST_INICIAL;
      case (r_estado)
         ST_INICIAL:        w_proximo = bus.iniciar ? ST_PREPARACAO : ST_INICIAL;
         ST_PREPARACAO:     w_proximo = ST_INICIA_RODADA;
         ST_INICIA_RODADA:  w_proximo = ST_ESPERA_JOGADA;
         // A play arriving together with the timeout still counts
         ST_ESPERA_JOGADA:  w_proximo = bus.jogada_feita ? ST_REGISTRA :
                                        bus.fimT         ? ST_FIM_TIMEOUT :
                                                           ST_ESPERA_JOGADA;
         ST_REGISTRA:       w_proximo = ST_COMPARACAO;
         ST_COMPARACAO: begin
            if (!bus.igual)          w_proximo = ST_FIM_ERROU;
            else if (!bus.fimRodada) w_proximo = ST_PROXIMA_JOGADA;
            else if (!bus.fimTotal)  w_proximo = ST_PROXIMA_RODADA;
            else                     w_proximo = ST_FIM_ACERTOU;
         end
         ST_PROXIMA_JOGADA: w_proximo = ST_ESPERA_JOGADA;
         ST_PROXIMA_RODADA: w_proximo = ST_INICIA_RODADA;
         ST_FIM_ACERTOU:    w_proximo = bus.iniciar ? ST_PREPARACAO : ST_FIM_ACERTOU;
         ST_FIM_ERROU:      w_proximo = bus.iniciar ? ST_PREPARACAO : ST_FIM_ERROU;
         ST_FIM_TIMEOUT:    w_proximo = bus.iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
         default:           w_proximo = ST_INICIAL;
      endcase
   end

   // Moore output decode from the registered state only
   always_comb begin
      w_zeraCL    = 1'b0;
      w_contaCL   = 1'b0;
      w_zeraC     = 1'b0;
      w_contaC    = 1'b0;
      w_zeraR     = 1'b0;
      w_registraR = 1'b0;
      w_conta     = 1'b0;
      w_pronto    = 1'b0;
      w_acertou   = 1'b0;
      w_errou     = 1'b0;
      w_timeout   = 1'b0;
      w_db_estado = r_estado;
      case (r_estado)
         ST_INICIAL:        ;
         ST_PREPARACAO:     begin w_zeraCL = 1'b1; w_zeraC = 1'b1; w_zeraR = 1'b1; end
         ST_INICIA_RODADA:  begin w_zeraC = 1'b1; w_zeraR = 1'b1; end
         ST_ESPERA_JOGADA:  w_conta = 1'b1;
         ST_REGISTRA:       w_registraR = 1'b1;
         ST_COMPARACAO:     ;
         ST_PROXIMA_JOGADA: w_contaC = 1'b1;
         ST_PROXIMA_RODADA: w_contaCL = 1'b1;
         ST_FIM_ACERTOU:    begin w_pronto = 1'b1; w_acertou = 1'b1; end
         ST_FIM_ERROU:      begin w_pronto = 1'b1; w_errou = 1'b1; end
         ST_FIM_TIMEOUT:    begin w_pronto = 1'b1; w_timeout = 1'b1; end
         default:           w_db_estado = C_ST_INVALIDO;
      endcase
   end

   assign bus.zeraCL    = w_zeraCL;
   assign bus.contaCL   = w_contaCL;
   assign bus.zeraC     = w_zeraC;
   assign bus.contaC    = w_contaC;
   assign bus.zeraR     = w_zeraR;
   assign bus.registraR = w_registraR;
   assign bus.conta     = w_conta;
   assign bus.modo_jogo = r_modo_jogo;
   assign bus.pronto    = w_pronto;
   assign bus.acertou   = w_acertou;
   assign bus.errou     = w_errou;
   assign bus.timeout   = w_timeout;
   assign bus.db_estado = w_db_estado;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle_jogo.sv
// +----------------------------------------------------------------------+
// | Module      : tb_unidade_controle_jogo                               |
// | Description : Self-checking bench for unidade_controle_jogo with a   |
// |               game-level reference model and a bench-side datapath.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_unidade_controle_jogo;

   logic clock = 1'b0;
   logic reset = 1'b0;

   unidade_controle_jogo_if bus ();

   unidade_controle_jogo dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // Reference model: game phase as display code, latched mode, datapath counters
   logic [3:0] m_estado = 4'h0;
   logic       m_modo   = 1'b0;
   logic [3:0] m_rod    = 4'h0;
   logic [3:0] m_jog    = 4'h0;
   logic [10:0] m_e;

   // Bench datapath: flags derived from the model's counters
   assign bus.fimRodada = (m_jog == m_rod);
   assign bus.fimTotal  = (m_rod == (m_modo ? 4'd3 : 4'd15));

   // Required outputs per phase, packed as
   // {zeraCL,contaCL,zeraC,contaC,zeraR,registraR,conta,pronto,acertou,errou,timeout}
   function automatic logic [10:0] exp_outs(input logic [3:0] s);
      case (s)
         4'h1:    return 11'b101_0100_0000; // clear all counters and register
         4'h2:    return 11'b001_0100_0000; // clear play counter and register
         4'h3:    return 11'b000_0001_0000; // timeout counter runs
         4'h4:    return 11'b000_0010_0000; // load play register
         4'h6:    return 11'b000_1000_0000; // next play
         4'h7:    return 11'b010_0000_0000; // next round
         4'hA:    return 11'b000_0000_1100; // hit
         4'hE:    return 11'b000_0000_1010; // miss
         4'hD:    return 11'b000_0000_1001; // timeout
         default: return 11'b000_0000_0000;
      endcase
   endfunction

   function automatic logic terminal(input logic [3:0] s);
      return (s == 4'hA) || (s == 4'hE) || (s == 4'hD);
   endfunction

   function automatic logic [3:0] nxt(input logic [3:0] s);
      case (s)
         4'h0: return bus.iniciar ? 4'h1 : 4'h0;
         4'h1: return 4'h2;
         4'h2: return 4'h3;
         4'h3: return bus.jogada_feita ? 4'h4 : (bus.fimT ? 4'hD : 4'h3);
         4'h4: return 4'h5;
         4'h5: begin
            if (!bus.igual)          return 4'hE;
            else if (!bus.fimRodada) return 4'h6;
            else if (!bus.fimTotal)  return 4'h7;
            else                     return 4'hA;
         end
         4'h6: return 4'h3;
         4'h7: return 4'h2;
         4'hA, 4'hE, 4'hD: return bus.iniciar ? 4'h1 : s;
         default: return 4'h0;
      endcase
   endfunction

   // Model update on the same edges the controller sees
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_estado <= 4'h0;
         m_modo   <= 1'b0;
         m_rod    <= 4'h0;
         m_jog    <= 4'h0;
      end else begin
         m_e = exp_outs(m_estado);
         m_estado <= nxt(m_estado);
         if (m_estado == 4'h1) m_modo <= bus.modo;
         if (m_e[10])     m_rod <= 4'h0;
         else if (m_e[9]) m_rod <= m_rod + 4'h1;
         if (m_e[8])      m_jog <= 4'h0;
         else if (m_e[7]) m_jog <= m_jog + 4'h1;
      end
   end

   function automatic logic [10:0] dut_outs();
      return {bus.zeraCL, bus.contaCL, bus.zeraC, bus.contaC, bus.zeraR,
              bus.registraR, bus.conta, bus.pronto, bus.acertou, bus.errou, bus.timeout};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      checks++;
      failures++;
      $display("FAIL %s: cycle budget expired, model state %0h, dut state %0h",
               name, m_estado, bus.db_estado);
   endtask

   task automatic idle_inputs();
      bus.iniciar      = 1'b0;
      bus.jogada_feita = 1'b0;
      bus.fimT         = 1'b0;
      bus.igual        = 1'b1;
   endtask

   // From idle or a terminal state, request a game in the given mode
   task automatic start_game(input logic md);
      @(negedge clock);
      idle_inputs();
      bus.iniciar = 1'b1;
      bus.modo    = md;
      @(negedge clock);
      bus.iniciar = 1'b0;
   endtask

   // Play until the model reaches a terminal state; a miss is planted at
   // (round err_r, play err_j), counted from zero
   task automatic play(input int err_r, input int err_j, input bit tmo, output int ncl);
      int n;
      n   = 0;
      ncl = 0;
      while (!terminal(m_estado) && n < 3000) begin
         bus.jogada_feita = (m_estado == 4'h3) ? ($urandom_range(0, 99) < 60)
                                               : ($urandom_range(0, 99) < 10);
         bus.fimT    = tmo && ($urandom_range(0, 99) < 8);
         bus.igual   = !((int'(m_rod) == err_r) && (int'(m_jog) == err_j));
         bus.iniciar = ($urandom_range(0, 99) < 10);
         @(negedge clock);
         if (bus.contaCL) ncl++;
         n++;
      end
      idle_inputs();
      if (n >= 3000) bound_fail("play_budget");
   endtask

   // Drive quiet inputs until the model reaches phase s
   task automatic wait_state(input logic [3:0] s);
      int n;
      n = 0;
      while (m_estado != s && n < 50) begin
         idle_inputs();
         bus.jogada_feita = (s != 4'h3) && (m_estado == 4'h3);
         @(negedge clock);
         n++;
      end
      idle_inputs();
      if (n >= 50) bound_fail("wait_state");
   endtask

   initial begin
      int ncl;
      int md, er, ej;
      bus.modo = 1'b0;
      idle_inputs();

      // Reset state
      @(posedge clock);
      #1;
      check("reset_outputs", {17'd0, bus.db_estado, bus.modo_jogo, dut_outs()}, 32'd0);

      // Every-cycle comparison against the model
      fork
         forever begin
            @(negedge clock);
            check("per_cycle {db_estado,modo_jogo,outs}",
                  {bus.db_estado, bus.modo_jogo, dut_outs()},
                  {m_estado, m_modo, exp_outs(m_estado)});
         end
      join_none

      @(negedge clock);
      reset = 1'b1;

      // Mode 1, every play correct: four rounds of 1..4 plays
      start_game(1'b1);
      play(99, 99, 1'b0, ncl);
      check("m1_win_db_estado", {28'd0, bus.db_estado}, 32'hA);
      check("m1_win_pronto_acertou", {30'd0, bus.pronto, bus.acertou}, 32'd3);
      check("m1_win_contaCL_pulses", ncl, 32'd3);
      check("m1_win_modo_jogo", {31'd0, bus.modo_jogo}, 32'd1);

      // Restart from hit with mode changed to 0
      bus.iniciar = 1'b1;
      bus.modo    = 1'b0;
      @(posedge clock);
      #1;
      check("restart_preparacao", {28'd0, bus.db_estado}, 32'h1);
      check("restart_clears", {29'd0, bus.zeraCL, bus.zeraC, bus.zeraR}, 32'h7);
      @(negedge clock);
      bus.iniciar = 1'b0;
      @(posedge clock);
      #1;
      check("restart_inicia_rodada", {28'd0, bus.db_estado}, 32'h2);
      check("restart_modo_jogo", {31'd0, bus.modo_jogo}, 32'd0);

      // Mode 0, wrong value on round 2, play 2
      @(negedge clock);
      play(1, 1, 1'b0, ncl);
      check("m0_miss_db_estado", {28'd0, bus.db_estado}, 32'hE);
      check("m0_miss_errou_acertou", {30'd0, bus.errou, bus.acertou}, 32'd2);

      // No play while waiting, then the timeout counter expires
      start_game(1'b1);
      wait_state(4'h3);
      repeat (3) @(negedge clock);
      check("tmo_conta_waiting", {31'd0, bus.conta}, 32'd1);
      bus.fimT = 1'b1;
      @(posedge clock);
      #1;
      check("tmo_db_estado", {28'd0, bus.db_estado}, 32'hD);
      check("tmo_flags", {29'd0, bus.timeout, bus.pronto, bus.conta}, 32'h6);
      @(negedge clock);
      bus.fimT = 1'b0;

      // Play and timeout in the same cycle: the play wins
      start_game(1'b0);
      wait_state(4'h3);
      bus.jogada_feita = 1'b1;
      bus.fimT         = 1'b1;
      @(posedge clock);
      #1;
      check("simult_db_estado", {28'd0, bus.db_estado}, 32'h4);
      check("simult_registraR", {31'd0, bus.registraR}, 32'd1);
      @(negedge clock);
      idle_inputs();
      play(99, 99, 1'b0, ncl);
      check("m0_win_db_estado", {28'd0, bus.db_estado}, 32'hA);
      check("m0_win_contaCL_pulses", ncl, 32'd15);

      // Asynchronous reset while comparing
      start_game(1'b1);
      wait_state(4'h5);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_outputs", {17'd0, bus.db_estado, bus.modo_jogo, dut_outs()}, 32'd0);
      @(negedge clock);
      reset       = 1'b1;
      bus.iniciar = 1'b1;
      bus.modo    = 1'b1;
      @(posedge clock);
      #1;
      check("post_reset_preparacao", {27'd0, bus.db_estado, bus.zeraCL}, {27'd0, 4'h1, 1'b1});
      @(negedge clock);
      bus.iniciar = 1'b0;
      play(99, 99, 1'b1, ncl);

      // Randomized games
      for (int g = 0; g < 24; g++) begin
         md = int'($urandom_range(0, 1));
         if ($urandom_range(0, 99) < 50) begin
            er = int'($urandom_range(0, (md != 0) ? 3 : 15));
            ej = int'($urandom_range(0, er));
         end else begin
            er = 99;
            ej = 99;
         end
         start_game(md[0]);
         play(er, ej, ($urandom_range(0, 99) < 40), ncl);
      end

      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
